mem_access_unit: RTL

- Memory-side responder for the load/store control fields produced by the main decoder.
- Consumes `readreq`/`readtype` (LD, LWU, LW, LBU, LB) and `memwrite` (SD, SW, SB), plus an address and store data.
- Sequences one or two 32-bit beats on a word-wide data-memory port, then returns extended 64-bit load data.
- Stalls the pipeline while the access is in flight.

---
 rtl/mem_access_unit_if.sv | 14 +
 rtl/mem_access_unit.sv | 75 +++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide data-memory beat port between the access unit and memory
// master (access unit) drives mem_en/mem_we/mem_be/mem_addr/mem_wdata, samples mem_rdata/mem_ready
// slave (memory) drives mem_rdata/mem_ready, samples the beat request
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  modport master (output mem_en, mem_we, mem_be, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave (input mem_en, mem_we, mem_be, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences LD/LW/LWU/LB/LBU and SD/SW/SB as 32-bit memory beats
// clk, reset (sync, active-low); readreq/readtype/memwrite/addr/wdata request from decode
// rdata extended load result; stall holds pipeline; done/misalign one-cycle pulses; mem beat port
module mem_access_unit #(parameter int ADDR_W = 32) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readreq,
  input  logic [2:0]        readtype,
  input  logic [1:0]        memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  mem_access_unit_if.master mem
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  state_t state, nxt;
  logic st;
  logic [1:0] mw;
  logic [2:0] rt;
  logic [ADDR_W-1:0] a;
  logic [63:0] wd;
  logic req, ok, go, two, en;
  logic [7:0] lb;
  logic [63:0] ext;
  always_comb begin
    req = readreq | (|memwrite);
    // stores take priority, so alignment is judged on the store width when memwrite is set
    ok = |memwrite ? (memwrite == 2'b11 ? addr[2:0] == 3'b0 : memwrite == 2'b01 ? addr[1:0] == 2'b0 : 1'b1)
       : readtype == 3'b100 ? addr[2:0] == 3'b0 : readtype[2] ? 1'b0 : readtype[1] ? 1'b1 : addr[1:0] == 2'b0;
    go = state == IDLE && req && ok;
    two = st ? mw == 2'b11 : rt == 3'b100;
    en = state == BEAT0 || state == BEAT1;
    nxt = state == IDLE ? (go ? BEAT0 : IDLE)
        : state == DONE ? IDLE
        : !mem.mem_ready ? state
        : state == BEAT0 && two ? BEAT1 : DONE;
    stall = reset && (go || en);
    misalign = reset && state == IDLE && req && !ok;
    done = state == DONE;
    mem.mem_en = en;
    mem.mem_we = en && st;
    mem.mem_be = !en ? 4'h0 : st && mw == 2'b10 ? 4'b0001 << a[1:0] : 4'hf;
    mem.mem_addr = !en ? '0 : {a[ADDR_W-1:2], 2'b00} + (state == BEAT1 ? ADDR_W'(4) : '0);
    mem.mem_wdata = !(en && st) ? 32'h0 : mw == 2'b10 ? {4{wd[7:0]}} : state == BEAT1 ? wd[63:32] : wd[31:0];
    lb = mem.mem_rdata[{a[1:0], 3'b000} +: 8];
    ext = rt[1] ? (rt[0] ? {56'h0, lb} : {{56{lb[7]}}, lb})
        : (rt[0] ? {32'h0, mem.mem_rdata} : {{32{mem.mem_rdata[31]}}, mem.mem_rdata});
  end
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= nxt;
  // an LD parks its first beat in the unused low half of the store-data latch
  always_ff @(posedge clk)
    if (!reset) begin
      rdata <= '0;
      st <= 1'b0;
      mw <= 2'b00;
      rt <= 3'b000;
      a <= '0;
      wd <= '0;
    end else if (go) begin
      st <= |memwrite;
      mw <= memwrite;
      rt <= readtype;
      a <= addr;
      wd <= wdata;
    end else if (state == BEAT0 && mem.mem_ready && !st) begin
      if (two) wd[31:0] <= mem.mem_rdata;
      else rdata <= ext;
    end else if (state == BEAT1 && mem.mem_ready && !st)
      rdata <= {mem.mem_rdata, wd[31:0]};
endmodule
